// File: rtl/sincos_rr_sched_if.sv
// rtl/sincos_rr_sched_if.sv - request/response handshake bundle for the sincos round-robin scheduler
interface sincos_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]      req_valid;
  logic [16*NREQ-1:0]   req_phase;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [15:0]          rsp_g0;
  logic [15:0]          rsp_g1;

  // Requesters and response consumer side.
  modport master (
    output req_valid, req_phase, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_g0, rsp_g1
  );

  // Scheduler side.
  modport slave (
    input  req_valid, req_phase, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_g0, rsp_g1
  );
endinterface

// File: rtl/sincos_rr_sched.sv
// rtl/sincos_rr_sched.sv - round-robin sharing of one combinational sincos unit among NREQ requesters
module sincos_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sincos_rr_sched_if.slave     bus,
  output logic [15:0]          sc_u1,
  input  logic [15:0]          sc_g0,
  input  logic [15:0]          sc_g1,
  output logic                 busy
);

  logic              s1_valid;
  logic [15:0]       s1_phase;
  logic [IDW-1:0]    s1_id;
  logic [IDW-1:0]    ptr;
  logic [IDW-1:0]    ptr_next;
  logic [IDW-1:0]    grant;
  logic [15:0]       grant_phase;
  logic              s2_load;
  logic              s1_accept;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_g0;
  logic [15:0]       rsp_g1;

  // Pick the first valid requester starting at ptr, wrapping at NREQ (not 2^IDW).
  always_comb begin
    logic             found;
    logic [NREQ-1:0]  shifted;
    int               j;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      shifted = bus.req_valid >> j;
      if (!found && shifted[0]) begin
        grant = IDW'(j);
        found = 1'b1;
      end
    end
  end

  // Phase of the granted requester and the pointer position just past it.
  always_comb begin
    grant_phase = '0;
    for (int k = 0; k < NREQ; k++)
      if (grant == IDW'(k)) grant_phase = bus.req_phase[16*k +: 16];
    if (int'(grant) + 1 >= NREQ) ptr_next = '0;
    else ptr_next = grant + IDW'(1);
  end

  // S2 takes S1 whenever the output register is empty or draining; S1 refills in the same cycle.
  assign s2_load   = s1_valid && (!rsp_valid || bus.rsp_ready);
  assign s1_accept = rst_n && (!s1_valid || s2_load) && (|bus.req_valid);

  // One-hot accept strobe back to the requesters.
  always_comb begin
    bus.req_ready = '0;
    for (int k = 0; k < NREQ; k++)
      bus.req_ready[k] = s1_accept && (grant == IDW'(k));
  end

  // Issue and output pipeline stages plus the round-robin pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_phase  <= '0;
      s1_id     <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_g0    <= '0;
      rsp_g1    <= '0;
    end else begin
      if (s2_load) begin
        rsp_g0    <= sc_g0;
        rsp_g1    <= sc_g1;
        rsp_id    <= s1_id;
        rsp_valid <= 1'b1;
      end else if (rsp_valid && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
      end
      if (s1_accept) begin
        s1_phase <= grant_phase;
        s1_id    <= grant;
        s1_valid <= 1'b1;
        ptr      <= ptr_next;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // The shared unit sees a quiet zero phase when nothing is issued.
  assign sc_u1         = s1_valid ? s1_phase : 16'h0000;
  assign busy          = rst_n && (s1_valid || rsp_valid);
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_id    = rsp_id;
  assign bus.rsp_g0    = rsp_g0;
  assign bus.rsp_g1    = rsp_g1;

endmodule

// File: doc/sincos_rr_sched.md
Name: sincos_rr_sched

Overview:
- Round-robin scheduler that shares one combinational sincos datapath among NREQ phase requesters.
- Each requester presents a 16-bit phase word (u1 format: [15:14] quadrant, [13:0] in-quadrant offset) over a valid/ready handshake.
- The block registers the granted phase and drives it to the shared sincos instance, then registers g0 (sin) and g1 (cos) with the requester ID on a valid/ready response channel.
- Sits between the uniform-source/Box-Muller front end and the shared sincos unit in the AWGN generator.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_phase  in  16*NREQ  per-requester phase; requester i uses bits [16i+15:16i].
- req_ready  out  NREQ  one-hot grant/accept; asserted only for the requester accepted this cycle.
- sc_u1  out  16  phase driven to the shared sincos u1 input.
- sc_g0  in  16  signed sin result from the shared sincos; combinational in sc_u1.
- sc_g1  in  16  signed cos result from the shared sincos; combinational in sc_u1.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester that owns the response.
- rsp_g0  out  16  registered sin result.
- rsp_g1  out  16  registered cos result.
- busy  out  1  high when either pipeline stage holds valid data.

Behaviour:
- Two pipeline stages:
  - S1 (issue): s1_valid, s1_phase, s1_id.
  - S2 (output): rsp_valid, rsp_id, rsp_g0, rsp_g1.
- sc_u1 = s1_phase whenever s1_valid; sc_u1 = 16'h0000 when S1 is empty.
- S2 load condition: s2_load = s1_valid && (!rsp_valid || rsp_ready).
  - On s2_load: rsp_g0<=sc_g0, rsp_g1<=sc_g1, rsp_id<=s1_id, rsp_valid<=1.
  - Else if rsp_valid && rsp_ready: rsp_valid<=0.
  - rsp_g0, rsp_g1 and rsp_id hold their values while rsp_valid && !rsp_ready.
- S1 accept condition: s1_accept = (!s1_valid || s2_load) && |req_valid.
  - On s1_accept: capture the granted requester's phase and ID, s1_valid<=1.
  - Else if s2_load: s1_valid<=0.
- Arbitration: round-robin with pointer ptr (IDW bits, reset 0).
  - Grant goes to the first i with req_valid[i] set, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - req_ready[g]=1 only when s1_accept; req_ready is combinational from req_valid, ptr and pipeline state.
  - On accept, ptr <= (g+1) mod NREQ; ptr does not move when nothing is accepted.
- Throughput: 1 response per cycle with rsp_ready held high.
- Latency: request accepted at edge t gives rsp_valid high after edge t+1 (2-cycle latency, phase-to-response).
- Backpressure: with rsp_ready low, S2 holds and S1 holds. At most 2 transactions are in flight, then req_ready is all-zero.
- Requester side: req_phase must be stable while req_valid is high and not accepted. The block never drops or reorders a request; responses return in grant order.
- Simultaneous rsp_ready and new request while both stages are full: S2 drains, S1 advances to S2, and a new request is accepted into S1 in the same cycle.
- NREQ not a power of two: pointer wraps at NREQ, never at 2^IDW; IDs >= NREQ are never produced.
- Reset (rst_n low at an edge, including mid-transaction):
  - s1_valid=0, rsp_valid=0, ptr=0.
  - rsp_g0=0, rsp_g1=0, rsp_id=0, s1_phase=0.
  - In-flight transactions are discarded.
  - req_ready=0 and busy=0 while rst_n is low.
- busy = s1_valid | rsp_valid.

Test Plan:
- Reset then single request: req_valid=4'b0001, phase 16'h0000 -> req_ready[0] for 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_g0=16'h0000, rsp_g1=16'h7FFF (values match the sincos model).
- Boundary phase: requester 2 sends 16'h4000 -> rsp_id=2, rsp_g0=16'h7FFF, rsp_g1=16'h0000. Requester 3 sends 16'hC000 -> rsp_g0=16'h8001, rsp_g1=16'h0000.
- Fairness: all four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 with one response per cycle. Drop req_valid[1] -> order continues 2,3,0,2.
- Backpressure: rsp_ready=0 with requests pending -> exactly 2 accepts, then req_ready=0. rsp_g0/rsp_g1/rsp_id stay stable. Raising rsp_ready drains in order with no loss or duplication.
- Reset mid-operation: both stages full, assert rst_n=0 for 1 cycle -> rsp_valid=0, busy=0, ptr=0. The next grant goes to the lowest valid index and no stale response appears.
- Randomised soak, NREQ=3 with IDW=2: random valid/ready for 10k cycles -> scoreboard confirms per-requester in-order responses, correct IDs, no ID 3, and g0/g1 match the model.
